// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus controller: FSM state
// encoding and the default address window / timeout settings.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ    = 2'b01,
        WAIT_R = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [31:0] DEFAULT_DMEM_BASE = 32'h1001_0000;
    localparam logic [31:0] DEFAULT_DMEM_SIZE = 32'h0001_0000;
    localparam int          DEFAULT_TIMEOUT   = 16;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational screening of a core access: flags simultaneous read and
// write, a non-word-aligned address, or an address outside the data window.
// The window compare is done in 33 bits so BASE+SIZE cannot wrap to zero.
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DEFAULT_DMEM_BASE,
    parameter logic [31:0] DMEM_SIZE = DEFAULT_DMEM_SIZE
) (
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    output logic        addr_err
);

    logic [32:0] addr_ext;
    logic [32:0] win_lo;
    logic [32:0] win_hi;
    logic        conflict;
    logic        misaligned;
    logic        out_of_range;

    assign addr_ext     = {1'b0, address};
    assign win_lo       = {1'b0, DMEM_BASE};
    assign win_hi       = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};

    assign conflict     = mem_read & mem_write;
    assign misaligned   = |address[1:0];
    assign out_of_range = (addr_ext < win_lo) || (addr_ext >= win_hi);

    assign addr_err     = conflict | misaligned | out_of_range;

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller for the multicycle core. Converts MEM-stage
// loads/stores into req/gnt/rvalid bus transactions, stalls the core while
// they are in flight, and reports rejected or timed-out accesses on memErr.
module dmem_bus_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE = DEFAULT_DMEM_BASE,
    parameter logic [31:0] DMEM_SIZE = DEFAULT_DMEM_SIZE,
    parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] dAddress,
    input  logic [31:0] dWriteData,
    output logic [31:0] dReadData,
    output logic        memBusy,
    output logic        memDone,
    output logic        memErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             next_state;
    logic               request;
    logic               addr_err;
    logic               timeout_hit;
    logic               err_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [CNT_W-1:0]   cnt;

    assign request     = MemRead | MemWrite;
    // True in the last REQ/WAIT_R cycle the budget allows.
    assign timeout_hit = (cnt == LAST_CNT);

    dmem_addr_check #(
        .DMEM_BASE (DMEM_BASE),
        .DMEM_SIZE (DMEM_SIZE)
    ) u_addr_check (
        .mem_read  (MemRead),
        .mem_write (MemWrite),
        .address   (dAddress),
        .addr_err  (addr_err)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; a completing gnt/rvalid wins over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    next_state = addr_err ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    next_state = we_q ? DONE : WAIT_R;
                end else if (timeout_hit) begin
                    next_state = DONE;
                end
            end
            WAIT_R: begin
                if (bus_rvalid || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Core handshake and bus request decoded from the current state.
    always_comb begin
        memBusy = 1'b0;
        memDone = 1'b0;
        memErr  = 1'b0;
        bus_req = 1'b0;
        case (state)
            IDLE: begin
                memBusy = request;
            end
            REQ: begin
                memBusy = 1'b1;
                bus_req = 1'b1;
            end
            WAIT_R: begin
                memBusy = 1'b1;
            end
            DONE: begin
                memDone = 1'b1;
                memErr  = err_q;
            end
            default: begin
                memBusy = 1'b0;
            end
        endcase
    end

    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    // Access latches, timeout counter, error flag and load-data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            dReadData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (request) begin
                        if (addr_err) begin
                            err_q <= 1'b1;
                            if (MemRead) begin
                                dReadData <= '0;
                            end
                        end else begin
                            err_q   <= 1'b0;
                            we_q    <= MemWrite;
                            addr_q  <= {dAddress[31:2], 2'b00};
                            wdata_q <= dWriteData;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!bus_gnt && timeout_hit) begin
                        err_q <= 1'b1;
                        if (!we_q) begin
                            dReadData <= '0;
                        end
                    end
                end
                WAIT_R: begin
                    cnt <= cnt + 1'b1;
                    if (bus_rvalid) begin
                        dReadData <= bus_rdata;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        dReadData <= '0;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule
